legv8_multicycle_control: RTL and testbench

Multi-cycle control unit for the LEGv8 datapath. Sequences fetch, decode, execute, memory and write-back by driving register enables, mux selects, ALU operation class and the immediate-format select used by the sign-extension stage. Owns a request/ready handshake to data memory and a retired-instruction counter. Sits beside the datapath and takes the opcode field from the instruction register.

---
 rtl/legv8_multicycle_control_if.sv | 36 +++
 rtl/legv8_multicycle_control.sv | 122 ++++++++++++
 tb/tb_legv8_multicycle_control.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/legv8_multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle for the LEGv8 multicycle core.
// Memory handshake: mem_read/mem_write is the request, held with stable imm_sel/alu_src_b until mem_ready; the access completes on the first edge where request and mem_ready are both high.
interface legv8_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic [1:0]       imm_sel;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             mem_to_reg;
  logic [1:0]       pc_src;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       dbg_state;

  // Datapath / memory side.
  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, imm_sel, alu_src_b, alu_op, mem_read, mem_write,
           reg_write, mem_to_reg, pc_src, illegal, retired, dbg_state
  );

  // Control unit side.
  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, imm_sel, alu_src_b, alu_op, mem_read, mem_write,
           reg_write, mem_to_reg, pc_src, illegal, retired, dbg_state
  );
endinterface

// File: rtl/legv8_multicycle_control.sv
// Moore-style multicycle control for LEGv8: registered control word per state,
// memory request/ready wait states and a retired-instruction counter.
module legv8_multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic                      clock,
  input logic                      reset,
  legv8_multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_CBZ, S_BRANCH, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [1:0] imm_sel;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic       is_cbz;
  } ctrl_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;

  state_t           r_state;
  state_t           w_next;
  ctrl_t            r_ctrl;
  logic             r_is_load;
  logic [CNT_W-1:0] r_retired;
  logic             w_cbz_taken;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      S_EXEC_R:   c.alu_op = 2'b10;
      S_EXEC_I:   begin c.alu_op = 2'b11; c.alu_src_b = 1'b1; c.imm_sel = 2'b01; end
      S_WB_ALU:   c.reg_write = 1'b1;
      S_MEM_ADDR: begin c.alu_src_b = 1'b1; c.imm_sel = 2'b11; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.alu_src_b = 1'b1; c.imm_sel = 2'b11; end
      S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.alu_src_b = 1'b1; c.imm_sel = 2'b11; end
      S_CBZ:      begin c.alu_op = 2'b01; c.imm_sel = 2'b10; c.is_cbz = 1'b1; end
      S_BRANCH:   begin c.pc_write = 1'b1; c.pc_src = 2'b01; end
      S_TRAP:     c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        casez (bus.opcode)
          11'b10001011000, 11'b11001011000,
          11'b10001010000, 11'b10101010000: w_next = S_EXEC_R;
          11'b1001000100?:                   w_next = S_EXEC_I;
          11'b11111000010, 11'b11111000000:  w_next = S_MEM_ADDR;
          11'b10110100???:                   w_next = S_CBZ;
          11'b000101?????:                   w_next = S_BRANCH;
          default:                           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = r_is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_CBZ, S_BRANCH: w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_IDLE;
    endcase
  end

  // Control word is computed from the next state so outputs come straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ctrl    <= '0;
      r_is_load <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next);
      if (r_state == S_DECODE) begin
        r_is_load <= (bus.opcode == OP_LDUR);
      end
      // Only IDLE->FETCH is excluded; every other entry into FETCH retires one instruction.
      if (w_next == S_FETCH && r_state != S_IDLE) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // The CBZ PC load depends on the zero flag produced in the CBZ cycle itself.
  assign w_cbz_taken    = r_ctrl.is_cbz & bus.zero;
  assign bus.pc_write   = r_ctrl.pc_write | w_cbz_taken;
  assign bus.pc_src     = w_cbz_taken ? 2'b10 : r_ctrl.pc_src;
  assign bus.ir_write   = r_ctrl.ir_write;
  assign bus.imm_sel    = r_ctrl.imm_sel;
  assign bus.alu_src_b  = r_ctrl.alu_src_b;
  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.illegal    = r_ctrl.illegal;
  assign bus.retired    = r_retired;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Bench for legv8_multicycle_control: per-instruction expected control traces
// built from instruction timing rules, checked every cycle, plus directed cases.
module tb_legv8_multicycle_control;
  localparam int CNT_W = 4;
  localparam int W = 14;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_CBZ, K_B} kind_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  legv8_multicycle_control_if #(.CNT_W(CNT_W)) bus ();
  legv8_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int rd_cycles = 0;
  int rw_cycles = 0;
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] ret_q[$];
  logic [CNT_W-1:0] model_ret;

  // {pc_write, ir_write, imm_sel, alu_src_b, alu_op, mem_read, mem_write, reg_write, mem_to_reg, pc_src, illegal}
  function automatic logic [W-1:0] cw(input logic pcw, input logic irw, input logic [1:0] imm,
                                      input logic asb, input logic [1:0] aop, input logic mr,
                                      input logic mw, input logic rw, input logic m2r,
                                      input logic [1:0] psrc, input logic ill);
    return {pcw, irw, imm, asb, aop, mr, mw, rw, m2r, psrc, ill};
  endfunction

  localparam logic [W-1:0] C_NONE  = '0;
  localparam logic [W-1:0] C_FETCH = cw(1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_EXR   = cw(1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_EXI   = cw(1'b0, 1'b0, 2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_WBA   = cw(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_MADR  = cw(1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_MRD   = cw(1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_WBM   = cw(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
  localparam logic [W-1:0] C_MWR   = cw(1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [W-1:0] C_BR    = cw(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
  localparam logic [W-1:0] C_TRAP  = cw(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

  function automatic logic [W-1:0] c_cbz(input logic z);
    return cw(z, 1'b0, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, z ? 2'b10 : 2'b00, 1'b0);
  endfunction

  function automatic logic [10:0] gen_op(input kind_t k);
    logic [10:0] op;
    case (k)
      K_R: begin
        case ($urandom_range(0, 3))
          0: op = 11'b10001011000;
          1: op = 11'b11001011000;
          2: op = 11'b10001010000;
          default: op = 11'b10101010000;
        endcase
      end
      K_I:   op = {10'b1001000100, 1'($urandom)};
      K_LD:  op = 11'b11111000010;
      K_ST:  op = 11'b11111000000;
      K_CBZ: op = {8'b10110100, 3'($urandom)};
      default: op = {6'b000101, 5'($urandom)};
    endcase
    return op;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the expected queue.
  always @(negedge clock) begin : cmp
    logic [W-1:0]     e;
    logic [CNT_W-1:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = ret_q.pop_front();
      check("ctrl", {bus.pc_write, bus.ir_write, bus.imm_sel, bus.alu_src_b, bus.alu_op,
                     bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg,
                     bus.pc_src, bus.illegal}, e);
      check("retired", bus.retired, r);
    end
    if (bus.mem_read)  rd_cycles++;
    if (bus.reg_write) rw_cycles++;
  end

  // One clock cycle: entered just after a rising edge, drives inputs, queues expectation.
  task automatic cyc(input logic [W-1:0] word, input logic mr, input logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    exp_q.push_back(word);
    ret_q.push_back(model_ret);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_ret = '0;
    cyc(C_NONE, 1'($urandom), 1'($urandom));
    cyc(C_NONE, 1'($urandom), 1'($urandom));
    reset = 1'b0;
    cyc(C_NONE, 1'($urandom), 1'($urandom));
  endtask

  task automatic run_instr(input kind_t k, input int waits, input logic zc);
    bus.opcode = 11'($urandom);
    cyc(C_FETCH, 1'($urandom), 1'($urandom));
    bus.opcode = gen_op(k);
    cyc(C_NONE, 1'($urandom), 1'($urandom));
    case (k)
      K_R: begin
        cyc(C_EXR, 1'($urandom), 1'($urandom));
        cyc(C_WBA, 1'($urandom), 1'($urandom));
      end
      K_I: begin
        cyc(C_EXI, 1'($urandom), 1'($urandom));
        cyc(C_WBA, 1'($urandom), 1'($urandom));
      end
      K_LD: begin
        cyc(C_MADR, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= waits; i++) cyc(C_MRD, i == waits, 1'($urandom));
        cyc(C_WBM, 1'($urandom), 1'($urandom));
      end
      K_ST: begin
        cyc(C_MADR, 1'($urandom), 1'($urandom));
        for (int i = 0; i <= waits; i++) cyc(C_MWR, i == waits, 1'($urandom));
      end
      K_CBZ: cyc(c_cbz(zc), 1'($urandom), zc);
      default: cyc(C_BR, 1'($urandom), 1'($urandom));
    endcase
    model_ret = model_ret + CNT_W'(1);
  endtask

  initial begin
    logic [CNT_W-1:0] saved;
    reset = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    model_ret = '0;
    @(posedge clock);
    #1;
    do_reset();

    // ADD: reg_write for exactly one cycle, one retirement.
    rw_cycles = 0;
    bus.opcode = 11'b0;
    run_instr(K_R, 0, 1'b0);
    check("add_retired", bus.retired, 1);
    check("add_regwrite_cycles", rw_cycles, 1);

    // LDUR with three wait cycles: four request cycles.
    rd_cycles = 0;
    run_instr(K_LD, 3, 1'b0);
    check("ldur_read_cycles", rd_cycles, 4);
    check("ldur_retired", bus.retired, 2);

    run_instr(K_CBZ, 0, 1'b1);
    run_instr(K_CBZ, 0, 1'b0);
    run_instr(K_B, 0, 1'b0);
    run_instr(K_ST, 2, 1'b0);
    check("mixed_retired", bus.retired, 6);

    // Undefined opcode: TRAP is absorbing until reset.
    saved = model_ret;
    bus.opcode = 11'($urandom);
    cyc(C_FETCH, 1'($urandom), 1'($urandom));
    bus.opcode = 11'b11111111111;
    cyc(C_NONE, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 20; i++) cyc(C_TRAP, 1'($urandom), 1'($urandom));
    check("trap_illegal", bus.illegal, 1);
    check("trap_retired", bus.retired, saved);
    do_reset();
    check("reset_illegal", bus.illegal, 0);
    check("reset_retired", bus.retired, 0);

    // Randomized instruction mix.
    for (int n = 0; n < 250; n++) begin
      run_instr(kind_t'($urandom_range(0, 5)), $urandom_range(0, 4), 1'($urandom));
    end

    // Counter wrap at CNT_W=4.
    do_reset();
    for (int n = 0; n < 15; n++) run_instr(K_B, 0, 1'b0);
    check("wrap_15", bus.retired, 15);
    run_instr(K_B, 0, 1'b0);
    check("wrap_16", bus.retired, 0);

    // Asynchronous reset in the middle of a store wait.
    run_instr(K_B, 0, 1'b0);
    bus.opcode = 11'($urandom);
    cyc(C_FETCH, 1'b0, 1'b0);
    bus.opcode = 11'b11111000000;
    cyc(C_NONE, 1'b0, 1'b0);
    cyc(C_MADR, 1'b0, 1'b0);
    cyc(C_MWR, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    #1;
    check("stur_wait_write", bus.mem_write, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_mem_write", bus.mem_write, 0);
    check("async_retired", bus.retired, 0);
    do_reset();
    run_instr(K_I, 0, 1'b0);
    check("post_reset_retired", bus.retired, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
